sram_ctrl: RTL and testbench

Responder-side data-memory controller for the pipelined ARM core: it serves the MEM stage's 32-bit load/store requests against an external 16-bit asynchronous SRAM. It splits each word into two half-word accesses. While a transaction is in flight it deasserts `ready`; the CPU top uses that signal to freeze every pipeline register and the PC.

---
 rtl/sram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: data-memory responder for the pipelined core. Each 32-bit
// load/store is served as two 16-bit accesses to an asynchronous SRAM, and
// `ready` is held low while a transaction is in flight so that the CPU
// freezes its pipeline.
//
// Optional build macro: SRAM_POSTED_WRITE_EN. When it is defined, stores are
// posted: the store is accepted in IDLE with `ready` high, and the write
// drains without a DONE cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   wr_en, rd_en        store / load request from the MEM stage
//   address, write_data byte address and store data
//   read_data           registered load result
//   ready               combinational; high lets the MEM stage advance
//   SRAM_DQ             16-bit bidirectional SRAM data bus
//   SRAM_ADDR           half-word address into the SRAM
//   SRAM_WE_N           write strobe, active-low
//   SRAM_CE_N/OE_N/UB_N/LB_N  permanently enabled (tied low)
module sram_ctrl #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned WORD_W = 17;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SADR_W = 18;

`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [SADR_W-1:0]   sadr_q, sadr_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic [HALF_W-1:0]   dq_out_q, dq_out_d;

    logic [WORD_W-1:0]   word_in_c;
    logic                last_c;

    // Word index relative to the base; addresses below the base wrap.
    assign word_in_c = WORD_W'((address - DATA_W'(BASE_ADDR)) >> 2);
    assign last_c    = (cnt_q == CNT_W'(ACCESS_CYCLES - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sadr_q   <= '0;
            we_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            sadr_q   <= sadr_d;
            we_n_q   <= we_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    // Next state, handshake and next SRAM pin values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        word_d   = word_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready    = 1'b0;
        sadr_d   = '0;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = '0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (wr_en) begin
                    state_d = S_WR_LO;
                    word_d  = word_in_c;
                    wdata_d = write_data;
                    ready   = POSTED;
                end else if (rd_en) begin
                    state_d = S_RD_LO;
                    word_d  = word_in_c;
                end else begin
                    ready = 1'b1;
                end
            end
            S_RD_LO: begin
                if (last_c) begin
                    rdata_d[15:0] = SRAM_DQ;
                    state_d       = S_RD_HI;
                    cnt_d         = '0;
                end
            end
            S_RD_HI: begin
                if (last_c) begin
                    rdata_d[31:16] = SRAM_DQ;
                    state_d        = S_DONE;
                    cnt_d          = '0;
                end
            end
            S_WR_LO: begin
                if (last_c) begin
                    state_d = S_WR_HI;
                    cnt_d   = '0;
                end
            end
            S_WR_HI: begin
                if (last_c) begin
                    // A posted write has already released the pipeline.
                    state_d = POSTED ? S_IDLE : S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins are registered from the upcoming state so they line up with it.
        unique case (state_d)
            S_RD_LO: sadr_d = {word_d, 1'b0};
            S_RD_HI: sadr_d = {word_d, 1'b1};
            S_WR_LO: begin
                sadr_d   = {word_d, 1'b0};
                we_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                dq_out_d = wdata_d[15:0];
            end
            S_WR_HI: begin
                sadr_d   = {word_d, 1'b1};
                we_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                dq_out_d = wdata_d[31:16];
            end
            default: begin
                sadr_d = '0;
            end
        endcase
    end

    assign read_data = rdata_q;
    assign SRAM_ADDR = sadr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: one instance with the default access time, backed by
// an SRAM array model, and a second instance with ACCESS_CYCLES=1 whose data
// bus returns a fixed address-derived pattern.
module tb_sram_ctrl;

    localparam int AC = 2;

`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;

    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1;
    wire  [15:0] dq0, dq1;
    logic [17:0] addr0, addr1;
    logic        we_n0, we_n1;
    logic        ce0, oe0, ub0, lb0, ce1, oe1, ub1, lb1;

    always #5 clk = ~clk;

    sram_ctrl #(.BASE_ADDR(1024), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(rdata0), .ready(rdy0), .SRAM_DQ(dq0),
        .SRAM_ADDR(addr0), .SRAM_WE_N(we_n0),
        .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_ctrl #(.BASE_ADDR(1024), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(rdata1), .ready(rdy1), .SRAM_DQ(dq1),
        .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // SRAM array model: asynchronous read, write captured while WE_N is low.
    logic [15:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_a  = '0;
    logic [15:0] pre_d  = '0;
    logic        probe  = 1'b0;

    always @(posedge clk) begin
        if (pre_en)      mem[pre_a] <= pre_d;
        else if (!we_n0) mem[addr0[9:0]] <= dq0;
    end

    // During a probe the bench drives zeros so a stray DUT driver shows up.
    assign dq0 = probe ? 16'h0000 : (we_n0 ? mem[addr0[9:0]] : 16'hzzzz);
    assign dq1 = we_n1 ? (addr1[15:0] ^ 16'hA5A5) : 16'hzzzz;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs (compared on every falling edge).
    logic        chk_en = 1'b0;
    logic        e_ready, e1_ready, e_we_n, e1_we_n, e_rvld, e1_rvld;
    logic [17:0] e_addr, e1_addr;
    logic [15:0] e_dq, e1_dq;
    logic [31:0] e_rdata, e1_rdata;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(rdy0), 32'(e_ready));
            chk("sram_addr", 32'(addr0), 32'(e_addr));
            chk("we_n", 32'(we_n0), 32'(e_we_n));
            if (!e_we_n) chk("dq_write", 32'(dq0), 32'(e_dq));
            if (e_rvld)  chk("read_data", rdata0, e_rdata);
            chk("ac1_ready", 32'(rdy1), 32'(e1_ready));
            chk("ac1_sram_addr", 32'(addr1), 32'(e1_addr));
            chk("ac1_we_n", 32'(we_n1), 32'(e1_we_n));
            if (!e1_we_n) chk("ac1_dq_write", 32'(dq1), 32'(e1_dq));
            if (e1_rvld)  chk("ac1_read_data", rdata1, e1_rdata);
        end
    end

    // Current transaction as seen by the model.
    logic        t_wr, t_rd;
    logic [16:0] t_w;
    logic [31:0] t_wd;
    logic [31:0] old0 = '0, old1 = '0;
    logic [31:0] gold [int];

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Cycle k of a transaction whose request is seen at k=0, for access time n.
    task automatic model(input int n, input int k, input logic [31:0] old_r,
                         input logic [31:0] new_r, output logic o_ready,
                         output logic [17:0] o_addr, output logic o_we_n,
                         output logic [15:0] o_dq, output logic o_rvld,
                         output logic [31:0] o_rd);
        bit busy;
        busy    = (k >= 1) && (k <= 2 * n);
        o_ready = (k == 0) ? (POSTED && t_wr) : !busy;
        if (k >= 1 && k <= n)          o_addr = {t_w, 1'b0};
        else if (k > n && k <= 2 * n)  o_addr = {t_w, 1'b1};
        else                           o_addr = '0;
        o_we_n = !(t_wr && busy);
        o_dq   = (k <= n) ? t_wd[15:0] : t_wd[31:16];
        o_rvld = (k == 0) || (k > 2 * n) || t_wr;
        o_rd   = (t_rd && k > 2 * n) ? new_r : old_r;
    endtask

    task automatic set_idle();
        e_ready = 1'b1; e_addr = '0; e_we_n = 1'b1; e_dq = '0; e_rvld = 1'b1; e_rdata = old0;
        e1_ready = 1'b1; e1_addr = '0; e1_we_n = 1'b1; e1_dq = '0; e1_rvld = 1'b1; e1_rdata = old1;
    endtask

    // Runs one request; abort_at >= 0 pulls reset in that cycle instead.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] wd, input int abort_at);
        logic [31:0] new0, new1;
        t_wr = wr;
        t_rd = rd && !wr;
        t_w  = 17'((a - 32'd1024) >> 2);
        t_wd = wd;
        new0 = gold.exists(int'(t_w)) ? gold[int'(t_w)] : 32'h0;
        new1 = {pat({t_w, 1'b1}), pat({t_w, 1'b0})};
        for (int k = 0; k <= 2 * AC + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                chk_en = 1'b0;
                wr_en = 1'b0; rd_en = 1'b0;
                rst = 1'b0;
                #1;
                chk("rst_read_data", rdata0, 32'h0);
                chk("rst_ac1_read_data", rdata1, 32'h0);
                chk("rst_we_n", 32'(we_n0), 32'h1);
                chk("rst_sram_addr", 32'(addr0), 32'h0);
                chk("rst_ready", 32'(rdy0), 32'h1);
                probe = 1'b1;
                #1;
                chk("rst_dq_released", 32'(dq0), 32'h0);
                probe = 1'b0;
                old0 = '0;
                old1 = '0;
                @(negedge clk);
                rst = 1'b1;
                set_idle();
                chk_en = 1'b1;
                return;
            end
            if (k == 0) begin
                wr_en = wr; rd_en = rd; address = a; write_data = wd;
            end else begin
                // Later input activity must be ignored by a latched transaction.
                wr_en = 1'b0; rd_en = 1'b0;
                address = $urandom; write_data = $urandom;
            end
            model(AC, k, old0, new0, e_ready, e_addr, e_we_n, e_dq, e_rvld, e_rdata);
            model(1, k, old1, new1, e1_ready, e1_addr, e1_we_n, e1_dq, e1_rvld, e1_rdata);
            chk_en = 1'b1;
        end
        if (t_wr) gold[int'(t_w)] = wd;
        if (t_rd) begin
            old0 = new0;
            old1 = new1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        set_idle();

        // Preload SRAM half-words 2/3 while reset is held.
        @(posedge clk); #1; pre_en = 1'b1; pre_a = 10'd2; pre_d = 16'h1234;
        @(posedge clk); #1; pre_a = 10'd3; pre_d = 16'h5678;
        @(posedge clk); #1; pre_en = 1'b0;
        gold[1] = 32'h5678_1234;

        chk("reset_tieoffs", {24'h0, ce0, oe0, ub0, lb0, ce1, oe1, ub1, lb1}, 32'h0);
        probe = 1'b1;
        #1;
        chk("reset_dq_released", 32'(dq0), 32'h0);
        probe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Write 0xDEADBEEF at the base: half-words 0 and 1.
        run_txn(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, -1);
        chk("write_lo_half", 32'(mem[0]), 32'h0000_BEEF);
        chk("write_hi_half", 32'(mem[1]), 32'h0000_DEAD);

        // Read of preloaded word 1.
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0, -1);
        chk("read_word1", rdata0, 32'h5678_1234);

        // Simultaneous requests: the write wins, read_data is untouched.
        run_txn(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, -1);
        chk("simul_lo_half", 32'(mem[4]), 32'h0000_F00D);
        chk("simul_hi_half", 32'(mem[5]), 32'h0000_CAFE);
        chk("simul_rdata_kept", rdata0, 32'h5678_1234);

        // Back-to-back read of the word just written.
        run_txn(1'b0, 1'b1, 32'd1032, 32'h0, -1);
        chk("read_word2", rdata0, 32'hCAFE_F00D);

        // Address below the base wraps to word 0x1FFFF.
        run_txn(1'b1, 1'b0, 32'd1020, 32'h0BAD_C0DE, -1);
        chk("wrap_lo_half", 32'(mem[10'h3FE]), 32'h0000_C0DE);
        run_txn(1'b0, 1'b1, 32'd1020, 32'h0, -1);
        chk("wrap_read", rdata0, 32'h0BAD_C0DE);

        // Reset in cycle 2 of a read.
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, 2);
        repeat (2) @(posedge clk);

        // Memory survives the controller reset.
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, -1);
        chk("read_after_reset", rdata0, 32'hDEAD_BEEF);
        @(posedge clk);

`ifdef SRAM_POSTED_WRITE_EN
        begin
            int frozen;
            bit seen;
            chk_en = 1'b0;
            @(posedge clk); #1;
            wr_en = 1'b1; address = 32'd1036; write_data = 32'h1122_3344;
            #1;
            chk("posted_write_ready", 32'(rdy0), 32'h1);
            @(posedge clk); #1;
            wr_en = 1'b0; rd_en = 1'b1; address = 32'd1036;
            frozen = 0;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (rdy0) seen = 1'b1;
                else frozen++;
            end
            chk("posted_read_done", 32'(seen), 32'h1);
            chk("posted_frozen_cycles", 32'(frozen), 32'(4 * AC + 1));
            chk("posted_read_data", rdata0, 32'h1122_3344);
            rd_en = 1'b0;
            repeat (6) @(posedge clk);
        end
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
